// File: rtl/rf_dbg_access.sv
// Debug-side initiator for the integer register file.
// Takes abstract read/write commands and returns one response beat per register.
module rf_dbg_access #(
  parameter int N_REGS = 16,
  parameter int XLEN   = 32,
  parameter int ID_W   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [ID_W-1:0] cmd_reg,
  input  logic [ID_W-1:0] cmd_count,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [ID_W-1:0] rsp_reg,
  output logic            rsp_err,
  output logic            rsp_last,
  output logic            req,
  input  logic            grant,
  output logic            rf_wen,
  output logic [ID_W-1:0] rf_rd,
  output logic [ID_W-1:0] rf_rs1,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [XLEN-1:0] rf_rdata1
);

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    REQ,
    ACCESS,
    RESP
  } state_t;

  localparam logic [ID_W:0] LIM = N_REGS[ID_W:0];

  state_t          state_q;
  state_t          state_d;
  logic            wr_q;
  logic [XLEN-1:0] wdata_q;
  logic [ID_W-1:0] cur_q;
  logic [ID_W-1:0] rem_q;
  logic [XLEN-1:0] rdata_q;
  logic [ID_W-1:0] rreg_q;

  logic [ID_W:0]   first_idx;
  logic [ID_W:0]   last_idx;
  logic            cmd_bad;
  logic            accept;
  logic            capture;
  logic            advance;
  logic            rem_zero;

  // Range math is one bit wider so reg+count cannot wrap back into range.
  assign first_idx = {1'b0, cmd_reg};
  assign last_idx  = {1'b0, cmd_reg} + {1'b0, cmd_count};
  assign cmd_bad   = (first_idx >= LIM) ||
                     (last_idx >= LIM) ||
                     (cmd_write && (cmd_count != '0));
  assign rem_zero  = (rem_q == '0);

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign capture = (state_q == ACCESS) && grant;
  assign advance = (state_q == RESP) && rsp_ready && !rem_zero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      rdata_q <= '0;
      rreg_q  <= '0;
    end else begin
      if (accept) begin
        wr_q    <= cmd_write;
        wdata_q <= cmd_wdata;
        cur_q   <= cmd_reg;
        rem_q   <= cmd_count;
        rdata_q <= '0;
        rreg_q  <= cmd_reg;
      end
      if (capture) begin
        rdata_q <= wr_q ? '0 : rf_rdata1;
        rreg_q  <= cur_q;
      end
      if (advance) begin
        cur_q <= cur_q + ID_W'(1);
        rem_q <= rem_q - ID_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_reg   = '0;
    rsp_err   = 1'b0;
    rsp_last  = 1'b0;
    req       = 1'b0;
    rf_wen    = 1'b0;
    rf_rd     = '0;
    rf_rs1    = '0;
    rf_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = cmd_bad ? ERR : REQ;
        end
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        rsp_last  = 1'b1;
        rsp_reg   = rreg_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        req = 1'b1;
        if (grant) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        req = 1'b1;
        if (grant) begin
          rf_rs1 = cur_q;
          if (wr_q) begin
            rf_rd    = cur_q;
            rf_wdata = wdata_q;
            rf_wen   = (cur_q != '0);
          end
          state_d = RESP;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_reg   = rreg_q;
        rsp_last  = rem_zero;
        req       = !rem_zero;
        if (rsp_ready) begin
          if (rem_zero) begin
            state_d = IDLE;
          end else begin
            state_d = grant ? ACCESS : REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_dbg_access.sv
// Bench for rf_dbg_access: register-file model, queue scoreboard,
// directed scenarios followed by randomized commands under random grant/backpressure.
module tb_rf_dbg_access;

  localparam int NR = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_reg;
  logic [4:0]  cmd_count;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_reg;
  logic        rsp_err;
  logic        rsp_last;
  logic        req;
  logic        grant;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [4:0]  rf_rs1;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata1;

  always #5 clock = ~clock;

  rf_dbg_access dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_reg(cmd_reg),
    .cmd_count(cmd_count), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_reg(rsp_reg),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .req(req), .grant(grant),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_rs1(rf_rs1),
    .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1)
  );

  // Core register file seen by the DUT
  logic [31:0] rf [NR] = '{default: 32'h0};
  always @(posedge clock)
    if (rf_wen && rf_rd != 5'd0 && rf_rd < 5'd16) rf[rf_rd[3:0]] <= rf_wdata;
  assign rf_rdata1 = (rf_rs1 < 5'd16) ? rf[rf_rs1[3:0]] : 32'h0;

  // Architectural reference contents
  logic [31:0] refm [NR] = '{default: 32'h0};

  typedef struct {
    logic [31:0] d;
    int          r;
    bit          e;
    bit          l;
  } beat_t;
  beat_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int popped = 0;
  int wen_cnt = 0;
  bit req_seen = 0;
  bit rnd = 0;

  always @(posedge clock) begin
    cyc++;
    if (rf_wen) wen_cnt++;
    if (req) req_seen = 1;
  end

  always @(posedge clock) begin
    if (rnd) begin
      #1;
      grant = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
    end
  endtask

  // Monitor: pops on handshake, checks stability while stalled
  bit          hold = 0;
  logic [31:0] hd;
  logic [4:0]  hr;
  logic        he, hl;
  beat_t       eb;
  always @(negedge clock) begin
    if (reset) begin
      hold = 0;
    end else if (rsp_valid) begin
      if (hold) begin
        chk("stable_rdata", rsp_rdata, hd);
        chk("stable_reg", 32'(rsp_reg), 32'(hr));
        chk("stable_err", 32'(rsp_err), 32'(he));
        chk("stable_last", 32'(rsp_last), 32'(hl));
      end
      if (rsp_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got reg %0d none expected", rsp_reg);
        end else begin
          eb = q.pop_front();
          chk("rsp_rdata", rsp_rdata, eb.d);
          chk("rsp_reg", 32'(rsp_reg), 32'(eb.r));
          chk("rsp_err", 32'(rsp_err), 32'(eb.e));
          chk("rsp_last", 32'(rsp_last), 32'(eb.l));
          popped++;
        end
        hold = 0;
      end else begin
        hold = 1;
        hd = rsp_rdata;
        hr = rsp_reg;
        he = rsp_err;
        hl = rsp_last;
      end
    end else begin
      if (hold) chk("valid_dropped", 32'(rsp_valid), 32'd1);
      hold = 0;
    end
  end

  task automatic issue(input bit w, input int r, input int c, input logic [31:0] d,
                       output bit bad, output int expw, output int acc);
    int k;
    bad = (r >= NR) || (r + c >= NR) || (w && c != 0);
    expw = 0;
    if (bad) begin
      q.push_back('{32'h0, r, 1'b1, 1'b1});
    end else if (w) begin
      q.push_back('{32'h0, r, 1'b0, 1'b1});
      if (r != 0) begin
        refm[r] = d;
        expw = 1;
      end
    end else begin
      for (int i = 0; i <= c; i++)
        q.push_back('{refm[r + i], r + i, 1'b0, i == c});
    end
    wen_cnt = 0;
    req_seen = 0;
    @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_reg = 5'(r);
    cmd_count = 5'(c);
    cmd_wdata = d;
    for (k = 0; k < 200; k++) begin
      @(negedge clock);
      if (cmd_ready) break;
    end
    if (k == 200) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got ready 0 expected 1");
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic finish_cmd(input bit bad, input int expw, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clock);
      if (q.size() == 0 && cmd_ready && !rsp_valid) break;
    end
    if (k == limit) begin
      checks++;
      errors++;
      $display("FAIL cmd_done_timeout: got %0d beats pending expected 0", q.size());
      q.delete();
    end
    chk("wen_pulses", wen_cnt, expw);
    if (bad) chk("req_on_err", 32'(req_seen), 32'd0);
  endtask

  task automatic run(input bit w, input int r, input int c, input logic [31:0] d);
    bit bad;
    int expw, acc;
    issue(w, r, c, d, bad, expw, acc);
    finish_cmd(bad, expw, 3000);
  endtask

  task automatic wait_popped(input int n);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clock);
      if (popped >= n) break;
    end
    if (k == 200) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got %0d beats expected %0d", popped, n);
    end
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clock);
      if (rsp_valid) break;
    end
    if (k == 200) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got rsp_valid 0 expected 1");
    end
  endtask

  initial begin
    bit bad;
    int expw, acc, p0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_reg = '0;
    cmd_count = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    grant = 1'b1;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Write then read x5, with latency check on the read
    run(1'b1, 5, 0, 32'hDEADBEEF);
    issue(1'b0, 5, 0, 32'h0, bad, expw, acc);
    wait_valid();
    chk("rsp_cycle", cyc - acc + 1, 3);
    finish_cmd(bad, expw, 100);

    // Preload xi = i*0x11, then dump all registers while spamming cmd_valid
    for (int i = 1; i < NR; i++) run(1'b1, i, 0, 32'(i * 32'h11));
    issue(1'b0, 0, 15, 32'h0, bad, expw, acc);
    @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_reg = 5'd7;
    cmd_count = 5'd0;
    repeat (10) @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    finish_cmd(bad, expw, 200);

    // Invalid commands
    run(1'b0, 16, 0, 32'h0);
    run(1'b0, 10, 6, 32'h0);
    run(1'b1, 3, 1, 32'h55);
    run(1'b0, 31, 31, 32'h0);

    // x0 write is a silent no-op
    run(1'b1, 0, 0, 32'h1234);
    run(1'b0, 0, 0, 32'h0);

    // Burst with backpressure on beat 1 and grant dropped before beat 2
    p0 = popped;
    issue(1'b0, 2, 3, 32'h0, bad, expw, acc);
    wait_popped(p0 + 1);
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    wait_valid();
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    grant = 1'b0;
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    grant = 1'b1;
    finish_cmd(bad, expw, 200);

    // Reset during RESP of beat 1 of a 4-beat burst
    p0 = popped;
    issue(1'b0, 0, 3, 32'h0, bad, expw, acc);
    wait_popped(p0 + 1);
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    wait_valid();
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_req", 32'(req), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    wen_cnt = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    rsp_ready = 1'b1;
    chk("abort_wen", wen_cnt, 0);
    run(1'b0, 9, 2, 32'h0);
    run(1'b1, 12, 0, 32'hCAFE0012);
    run(1'b0, 12, 0, 32'h0);

    // Random commands with random grant and backpressure
    rnd = 1'b1;
    for (int n = 0; n < 40; n++) begin
      bit w;
      int r, c;
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 17);
      if (w) c = ($urandom_range(0, 4) == 0) ? 1 : 0;
      else c = $urandom_range(0, 16);
      run(w, r, c, $urandom);
    end
    rnd = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
